cordic_quadrant_restore: RTL and testbench

//  Downstream post-stage of the CORDIC pipeline. Takes the folded-domain results (degree/x/y + sector flag)
//  and undoes the sector fold applied upstream.

---
 rtl/cordic_quadrant_restore_if.sv | 37 +++
 rtl/cordic_quadrant_restore.sv | 183 ++++++++++++++++++
 tb/tb_cordic_quadrant_restore.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cordic_quadrant_restore_if.sv
// Bundle of the sample-in, result-out and status signals of the quadrant
// restore stage. The master side drives samples and consumes results.
// The slave side is the restore stage itself.
interface cordic_quadrant_restore_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int DEG_OUT_WIDTH     = 17,
  parameter int SECTOR_FLAG_WIDTH = 2,
  parameter int FIFO_DEPTH        = 4
);
  logic [DATA_WIDTH-1:0]          degree_in;
  logic [DATA_WIDTH-1:0]          x_in;
  logic [DATA_WIDTH-1:0]          y_in;
  logic [SECTOR_FLAG_WIDTH-1:0]   sector_in;
  logic                           arctan_en_in;
  logic                           valid_in;
  logic                           overflow_clr;
  logic [DEG_OUT_WIDTH-1:0]       degree_out;
  logic [DATA_WIDTH-1:0]          x_out;
  logic [DATA_WIDTH-1:0]          y_out;
  logic                           arctan_en_out;
  logic                           valid_out;
  logic                           ready_in;
  logic [$clog2(FIFO_DEPTH):0]    level;
  logic                           overflow;

  modport master (
    output degree_in, x_in, y_in, sector_in, arctan_en_in, valid_in,
           overflow_clr, ready_in,
    input  degree_out, x_out, y_out, arctan_en_out, valid_out, level, overflow
  );

  modport slave (
    input  degree_in, x_in, y_in, sector_in, arctan_en_in, valid_in,
           overflow_clr, ready_in,
    output degree_out, x_out, y_out, arctan_en_out, valid_out, level, overflow
  );
endinterface

// File: rtl/cordic_quadrant_restore.sv
// CORDIC post-stage: undoes the upstream sector fold on x/y (rotation mode)
// or on the angle (vectoring mode), then queues results in a small
// show-ahead FIFO. The pipeline cannot stall, so a push into a full FIFO
// without a simultaneous pop drops the word and raises a sticky flag.
module cordic_quadrant_restore #(
  parameter int DATA_WIDTH        = 16,
  parameter int DEG_OUT_WIDTH     = 17,
  parameter int FRAC_WIDTH        = 8,
  parameter int SECTOR_FLAG_WIDTH = 2,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  cordic_quadrant_restore_if.slave     bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int DW1 = DEG_OUT_WIDTH + 1;
  localparam int WW  = DEG_OUT_WIDTH + 2 * DATA_WIDTH + 1;

  localparam logic signed [DW1-1:0] DEG_90  = DW1'(32'sd90  * (32'sd1 <<< FRAC_WIDTH));
  localparam logic signed [DW1-1:0] DEG_180 = DW1'(32'sd180 * (32'sd1 <<< FRAC_WIDTH));
  localparam logic signed [DW1-1:0] DEG_360 = DW1'(32'sd360 * (32'sd1 <<< FRAC_WIDTH));
  localparam logic [AW-1:0]         PTR_ONE  = AW'(1'b1);
  localparam logic [LW-1:0]         LVL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0]         LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]         LVL_ZERO = LW'(1'b0);

  // Two's-complement negate that maps the most negative code to the most positive.
  function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] a);
    if (a == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
      neg_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      neg_sat = -a;
    end
  endfunction

  logic signed [DW1-1:0]      deg_ext;
  logic signed [DW1-1:0]      deg_sum;
  logic signed [DW1-1:0]      deg_wrap;
  logic [DEG_OUT_WIDTH-1:0]   corr_deg;
  logic [DATA_WIDTH-1:0]      corr_x;
  logic [DATA_WIDTH-1:0]      corr_y;

  logic                       s1_valid;
  logic [WW-1:0]              s1_word;

  logic [WW-1:0]              mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [LW-1:0]              level_q;
  logic                       overflow_q;
  logic                       full;
  logic                       pop;
  logic                       wr_en;
  logic                       drop;
  logic [WW-1:0]              head;

  // Sector-fold correction of the incoming sample.
  always_comb begin
    deg_ext  = {{(DW1-DATA_WIDTH){bus.degree_in[DATA_WIDTH-1]}}, bus.degree_in};
    deg_sum  = deg_ext;
    deg_wrap = deg_ext;
    corr_deg = deg_ext[DEG_OUT_WIDTH-1:0];
    corr_x   = bus.x_in;
    corr_y   = bus.y_in;
    if (bus.arctan_en_in) begin
      case (bus.sector_in)
        2'd1:    deg_sum = deg_ext + DEG_90;
        2'd2:    deg_sum = deg_ext + DEG_180;
        2'd3:    deg_sum = deg_ext - DEG_90;
        default: deg_sum = deg_ext;
      endcase
      // Fold the angle back into (-180, 180].
      if (deg_sum > DEG_180) begin
        deg_wrap = deg_sum - DEG_360;
      end else if (deg_sum <= -DEG_180) begin
        deg_wrap = deg_sum + DEG_360;
      end else begin
        deg_wrap = deg_sum;
      end
      corr_deg = deg_wrap[DEG_OUT_WIDTH-1:0];
    end else begin
      case (bus.sector_in)
        2'd1: begin
          corr_x = neg_sat(bus.y_in);
          corr_y = bus.x_in;
        end
        2'd2: begin
          corr_x = neg_sat(bus.x_in);
          corr_y = neg_sat(bus.y_in);
        end
        2'd3: begin
          corr_x = bus.y_in;
          corr_y = neg_sat(bus.x_in);
        end
        default: begin
          corr_x = bus.x_in;
          corr_y = bus.y_in;
        end
      endcase
    end
  end

  // Stage-1 register: corrected word plus its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        s1_word <= {corr_deg, corr_x, corr_y, bus.arctan_en_in};
      end else begin
        s1_word <= s1_word;
      end
    end
  end

  assign full  = (level_q == LVL_FULL);
  assign pop   = (level_q != LVL_ZERO) & bus.ready_in;
  assign wr_en = s1_valid & (~full | pop);
  assign drop  = s1_valid & full & ~pop;

  // FIFO pointers and occupancy; a pop on a full FIFO frees the slot for a same-cycle push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      else       wr_ptr <= wr_ptr;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      else       rd_ptr <= rd_ptr;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage; contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr] <= s1_word;
    end
  end

  // Sticky overflow: a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign head = mem[rd_ptr];

  // Show-ahead output: head word while non-empty, zeros otherwise.
  always_comb begin
    bus.degree_out    = '0;
    bus.x_out         = '0;
    bus.y_out         = '0;
    bus.arctan_en_out = 1'b0;
    if (level_q != LVL_ZERO) begin
      {bus.degree_out, bus.x_out, bus.y_out, bus.arctan_en_out} = head;
    end else begin
      bus.arctan_en_out = 1'b0;
    end
  end

  assign bus.valid_out = (level_q != LVL_ZERO);
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cordic_quadrant_restore.sv
// Directed bench for cordic_quadrant_restore: stimulus pushes hand-computed
// expected words into a scoreboard queue; a monitor pops and compares on
// every accepted output word.
module tb_cordic_quadrant_restore;
  typedef struct packed {
    logic [16:0] deg;
    logic [15:0] x;
    logic [15:0] y;
    logic        mode;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  cordic_quadrant_restore_if bus ();

  cordic_quadrant_restore dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic mode, input logic [1:0] sec, input logic [15:0] d,
                      input logic [15:0] x, input logic [15:0] y, input logic [16:0] ed,
                      input logic [15:0] ex, input logic [15:0] ey, input bit keep);
    exp_t e;
    bus.arctan_en_in = mode;
    bus.sector_in    = sec;
    bus.degree_in    = d;
    bus.x_in         = x;
    bus.y_in         = y;
    bus.valid_in     = 1'b1;
    e.deg = ed; e.x = ex; e.y = ey; e.mode = mode;
    if (keep) sb.push_back(e);
    tick();
  endtask

  task automatic drain(input string name);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && !bus.valid_out) break;
      tick();
    end
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({name, "_valid_low"}, 32'(bus.valid_out), 32'd0);
    bus.ready_in = 1'b0;
  endtask

  // Scoreboard monitor: compare each word the consumer accepts.
  always @(negedge clk) begin
    if (!reset && bus.valid_out && bus.ready_in) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got deg %h x %h y %h expected none",
                 bus.degree_out, bus.x_out, bus.y_out);
      end else begin
        mon_e = sb.pop_front();
        check("head_deg",  32'(bus.degree_out),    32'(mon_e.deg));
        check("head_x",    32'(bus.x_out),         32'(mon_e.x));
        check("head_y",    32'(bus.y_out),         32'(mon_e.y));
        check("head_mode", 32'(bus.arctan_en_out), 32'(mon_e.mode));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.degree_in = 16'h0000; bus.x_in = 16'h0000; bus.y_in = 16'h0000;
    bus.sector_in = 2'd0; bus.arctan_en_in = 1'b0; bus.valid_in = 1'b0;
    bus.overflow_clr = 1'b0; bus.ready_in = 1'b0;
    tick(); tick();
    check("rst_valid",    32'(bus.valid_out),  32'd0);
    check("rst_level",    32'(bus.level),      32'd0);
    check("rst_overflow", 32'(bus.overflow),   32'd0);
    check("rst_deg",      32'(bus.degree_out), 32'd0);
    check("rst_x",        32'(bus.x_out),      32'd0);
    check("rst_y",        32'(bus.y_out),      32'd0);
    reset = 1'b0;
    tick();

    // T1 rotation fold, latency and hold under backpressure
    send(1'b0, 2'd1, 16'h1000, 16'h0100, 16'h0000, 17'h01000, 16'h0000, 16'h0100, 1'b1);
    bus.valid_in = 1'b0;
    check("t1_lat_s1", 32'(bus.valid_out), 32'd0);
    tick();
    check("t1_lat_out", 32'(bus.valid_out), 32'd1);
    check("t1_level",   32'(bus.level),     32'd1);
    tick(); tick();
    check("t1_hold_x", 32'(bus.x_out), 32'h0000);
    check("t1_hold_y", 32'(bus.y_out), 32'h0100);
    drain("t1");

    // T2 vectoring wrap, including both 180 boundaries
    send(1'b1, 2'd2, 16'h0A00, 16'h1234, 16'h0567, 17'h15600, 16'h1234, 16'h0567, 1'b1);
    send(1'b1, 2'd3, 16'h9C00, 16'h0800, 16'hF800, 17'h0AA00, 16'h0800, 16'hF800, 1'b1);
    send(1'b1, 2'd1, 16'h5A00, 16'h0100, 16'h0200, 17'h0B400, 16'h0100, 16'h0200, 1'b1);
    send(1'b1, 2'd3, 16'hA600, 16'h7FFF, 16'h8000, 17'h0B400, 16'h7FFF, 16'h8000, 1'b1);
    drain("t2");

    // T3 negation saturation and remaining folds
    send(1'b0, 2'd2, 16'h8000, 16'h8000, 16'h0100, 17'h18000, 16'h7FFF, 16'hFF00, 1'b1);
    send(1'b0, 2'd3, 16'h0200, 16'h0200, 16'h8000, 17'h00200, 16'h8000, 16'hFE00, 1'b1);
    send(1'b0, 2'd1, 16'hFF00, 16'h8000, 16'h0300, 17'h1FF00, 16'hFD00, 16'h8000, 1'b1);
    send(1'b1, 2'd0, 16'h8000, 16'h1111, 16'h2222, 17'h18000, 16'h1111, 16'h2222, 1'b1);
    drain("t3");

    // T4 backpressure: six words into a four-deep FIFO
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 2'd0, 16'(i << 8), 16'(16'h0010 + i), 16'(16'h0020 + i),
           17'(i << 8), 16'(16'h0010 + i), 16'(16'h0020 + i), (i < 4));
    end
    bus.valid_in = 1'b0;
    tick(); tick();
    check("t4_level",    32'(bus.level),    32'd4);
    check("t4_overflow", 32'(bus.overflow), 32'd1);
    drain("t4");
    check("t4_sticky", 32'(bus.overflow), 32'd1);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    check("t6_clr", 32'(bus.overflow), 32'd0);

    // Clear coinciding with a fresh drop keeps the flag set
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 2'd0, 16'h0000, 16'(16'h0040 + i), 16'h0000,
           17'h00000, 16'(16'h0040 + i), 16'h0000, (i < 4));
    end
    bus.valid_in = 1'b0;
    bus.overflow_clr = 1'b1;
    tick();
    check("clr_vs_drop", 32'(bus.overflow), 32'd1);
    tick();
    bus.overflow_clr = 1'b0;
    check("clr_after", 32'(bus.overflow), 32'd0);
    drain("t4b");

    // T5 full FIFO with simultaneous push and pop
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 2'd2, 16'h0000, 16'(16'h0100 + i), 16'(16'h0200 + i),
           17'h00000, 16'(-(16'h0100 + i)), 16'(-(16'h0200 + i)), 1'b1);
    end
    check("t5_full", 32'(bus.level), 32'd4);
    bus.ready_in = 1'b1;
    for (int i = 5; i < 8; i++) begin
      send(1'b0, 2'd2, 16'h0000, 16'(16'h0100 + i), 16'(16'h0200 + i),
           17'h00000, 16'(-(16'h0100 + i)), 16'(-(16'h0200 + i)), 1'b1);
      check("t5_level",    32'(bus.level),    32'd4);
      check("t5_overflow", 32'(bus.overflow), 32'd0);
    end
    drain("t5");
    check("t5_no_overflow", 32'(bus.overflow), 32'd0);

    // T6 reset mid-stream with three queued words and one in stage 1
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 2'd0, 16'h0000, 16'h0ABC, 16'h0DEF, 17'h00000, 16'h0ABC, 16'h0DEF, 1'b1);
    end
    bus.valid_in = 1'b0;
    check("t6_pre_level", 32'(bus.level), 32'd3);
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    check("t6_level", 32'(bus.level),     32'd0);
    check("t6_valid", 32'(bus.valid_out), 32'd0);
    check("t6_x",     32'(bus.x_out),     32'd0);
    tick(); tick(); tick();
    check("t6_s1_discarded", 32'(bus.level), 32'd0);
    send(1'b0, 2'd3, 16'h0100, 16'h0300, 16'h0400, 17'h00100, 16'h0400, 16'hFD00, 1'b1);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
